// File: rtl/accumulate_scan.sv
// accumulate_scan: prefix-sum / reduction engine over an internal DATA_W x DEPTH array.
// Define ACCUM_SAT_EN for a saturating adder and a sticky ovf output; otherwise arithmetic wraps.
module accumulate_scan #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i_t_a,
  input  logic [ADDR_W:0]   end_i_t_a,
  input  logic [DATA_W-1:0] init_acc_t_a,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  input  logic              controlArr,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  input  logic [DATA_W-1:0] controlArrWData_a
`ifdef ACCUM_SAT_EN
  ,
  output logic              ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for r_enable
  // RD    | engine index presented to the array read port
  // WR    | read data back: accumulate, optional write, advance index
  // FIN   | publish result, raise w_enable
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_E = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;

  logic [ADDR_W:0]   idx_q, end_q, end_clamped;
  logic [DATA_W-1:0] acc_q, result_q, sum;
  logic [1:0]        mode_q;
  logic              wen_q;
  logic              start, step, finish, last, start_empty;
  logic              eng_we;
  logic [DATA_W-1:0] eng_wdata;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] raddr_q, mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  assign end_clamped = (end_i_t_a > DEPTH_E) ? DEPTH_E : end_i_t_a;
  // An init index at or beyond DEPTH always lands here since the end is clamped to DEPTH.
  assign start_empty = ({1'b0, init_i_t_a} >= end_clamped);
  assign last        = ((idx_q + 1'b1) == end_q);

`ifdef ACCUM_SAT_EN
  logic [DATA_W:0] sum_ext;
  logic            sum_ovf;
  logic            ovf_q;

  always_comb begin
    sum_ext = {acc_q[DATA_W-1], acc_q} + {mem_rdata[DATA_W-1], mem_rdata};
    sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    sum     = sum_ext[DATA_W-1:0];
    if (sum_ovf) begin
      sum = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  assign ovf = ovf_q;
`else
  assign sum = acc_q + mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // r_enable wins over everything, including a pending FIN or an in-flight write.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    eng_we    = 1'b0;
    eng_wdata = sum;
    if (r_enable) begin
      start   = 1'b1;
      state_d = start_empty ? S_FIN : S_RD;
    end else begin
      case (state_q)
        S_RD: begin
          if (!controlArr) state_d = S_WR;
        end
        S_WR: begin
          // External port may have clobbered the registered read address: re-read.
          if (controlArr) begin
            state_d = S_RD;
          end else begin
            step      = 1'b1;
            eng_we    = (mode_q == 2'd0) || (mode_q == 2'd1);
            eng_wdata = (mode_q == 2'd1) ? acc_q : sum;
            state_d   = last ? S_FIN : S_RD;
          end
        end
        S_FIN: begin
          if (!controlArr) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      end_q    <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      wen_q    <= 1'b0;
`ifdef ACCUM_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else if (start) begin
      idx_q  <= {1'b0, init_i_t_a};
      end_q  <= end_clamped;
      acc_q  <= init_acc_t_a;
      mode_q <= mode;
      wen_q  <= 1'b0;
`ifdef ACCUM_SAT_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (step) begin
        acc_q <= sum;
        idx_q <= idx_q + 1'b1;
`ifdef ACCUM_SAT_EN
        ovf_q <= ovf_q | sum_ovf;
`endif
      end
      if (finish) begin
        result_q <= acc_q;
        wen_q    <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign w_enable = wen_q;
  assign result   = result_q;

  assign mem_addr  = controlArr ? controlArrAddr_a    : idx_q[ADDR_W-1:0];
  assign mem_we    = controlArr ? controlArrWEnable_a : eng_we;
  assign mem_wdata = controlArr ? controlArrWData_a   : eng_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if ({1'b0, mem_addr} < DEPTH_E) mem[mem_addr] <= mem_wdata;
    end else begin
      raddr_q <= mem_addr;
    end
  end

  assign mem_rdata         = mem[raddr_q];
  assign controlArrRData_a = mem_rdata;

endmodule

// File: tb/tb_accumulate_scan.sv
// Self-checking bench for accumulate_scan (DATA_W=8, DEPTH=12) against a behavioural scan model.
module tb_accumulate_scan;
  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXV  = 127;
  localparam int MINV  = -128;
  localparam int BIG   = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r_enable = 1'b0;
  logic [AW-1:0] init_i_t_a = '0;
  logic [AW:0]   end_i_t_a = '0;
  logic [DW-1:0] init_acc_t_a = '0;
  logic [1:0]    mode = '0;
  logic          busy, w_enable;
  logic [DW-1:0] result;
  logic          controlArr = 1'b0;
  logic          controlArrWEnable_a = 1'b0;
  logic [AW-1:0] controlArrAddr_a = '0;
  logic [DW-1:0] controlArrRData_a;
  logic [DW-1:0] controlArrWData_a = '0;
`ifdef ACCUM_SAT_EN
  logic          ovf;
`endif

  accumulate_scan #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable),
    .init_i_t_a(init_i_t_a), .end_i_t_a(end_i_t_a), .init_acc_t_a(init_acc_t_a), .mode(mode),
    .busy(busy), .w_enable(w_enable), .result(result),
    .controlArr(controlArr), .controlArrWEnable_a(controlArrWEnable_a),
    .controlArrAddr_a(controlArrAddr_a), .controlArrRData_a(controlArrRData_a),
    .controlArrWData_a(controlArrWData_a)
`ifdef ACCUM_SAT_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int model_mem [DEPTH];
  int start_cyc = 0, done_cyc = 0, res_old = 0, res_new = 0;
  bit wen_valid = 1'b0, chk_en = 1'b0, ovf_new = 1'b0;
  int n_cmp = 0, n_fail = 0;
  int exp_incl [5] = '{1, 3, 6, 10, 15};
  int exp_excl [5] = '{10, 11, 13, 16, 20};

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies up to lim element updates to the model array; n is the full element count.
  function automatic void model_scan(input int s, input int e, input int a0, input int md,
                                     input int lim, output int res, output bit ov, output int n);
    int ee, acc, raw;
    logic [DW-1:0] raw8;
    ee  = (e > DEPTH) ? DEPTH : e;
    n   = (s < ee) ? ee - s : 0;
    acc = a0;
    ov  = 1'b0;
    for (int j = 0; j < n && j < lim; j++) begin
      raw = acc + model_mem[s+j];
`ifdef ACCUM_SAT_EN
      if (raw > MAXV) begin raw = MAXV; ov = 1'b1; end
      else if (raw < MINV) begin raw = MINV; ov = 1'b1; end
`else
      raw8 = raw[DW-1:0];
      raw  = $signed(raw8);
`endif
      if (md == 0) model_mem[s+j] = raw;
      else if (md == 1) model_mem[s+j] = acc;
      acc = raw;
    end
    res = acc;
  endfunction

  always @(negedge clk) begin
    int m;
    bit eb, ew;
    if (chk_en) begin
      m  = cyc;
      eb = (m > start_cyc) && (m < done_cyc);
      ew = wen_valid && (m >= done_cyc);
      check("busy", busy, eb);
      check("w_enable", w_enable, ew);
      check("result", $signed(result), ew ? res_new : res_old);
`ifdef ACCUM_SAT_EN
      if (ew) check("ovf", ovf, ovf_new);
`endif
    end
  end

  task automatic wr_arr(input int a, input int v);
    controlArr = 1'b1; controlArrWEnable_a = 1'b1;
    controlArrAddr_a = AW'(a); controlArrWData_a = DW'(v);
    @(posedge clk); #1;
    controlArr = 1'b0; controlArrWEnable_a = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic rd_check(input int a, input string name);
    controlArr = 1'b1; controlArrWEnable_a = 1'b0; controlArrAddr_a = AW'(a);
    @(posedge clk); #1;
    check(name, $signed(controlArrRData_a), model_mem[a]);
    controlArr = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that samples r_enable.
  task automatic start_scan(input int s, input int e, input int acc, input int md,
                            input int stall, input int lim);
    int k, res, n;
    bit ov;
    k = cyc;
    init_i_t_a = AW'(s); end_i_t_a = (AW+1)'(e); init_acc_t_a = DW'(acc); mode = 2'(md);
    r_enable = 1'b1;
    model_scan(s, e, acc, md, lim, res, ov, n);
    @(posedge clk);
    if (wen_valid && k >= done_cyc) res_old = res_new;
    start_cyc = k; done_cyc = k + 2*n + 2 + stall; wen_valid = 1'b1;
    res_new = res; ovf_new = ov;
    #1 r_enable = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < done_cyc + 1) begin @(posedge clk); #1; end
  endtask

  task automatic wait_wen(input string name, input int lat);
    int t;
    t = 0;
    while (!w_enable && t < 100) begin @(posedge clk); #1; t++; end
    check(name, cyc - start_cyc, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_result", $signed(result), 0);
    for (int i = 0; i < DEPTH; i++) wr_arr(i, 0);

    // inclusive prefix sum
    for (int i = 0; i < 5; i++) wr_arr(i, i + 1);
    start_scan(0, 5, 0, 0, 0, BIG);
    wait_wen("incl_latency", 12);
    wait_done();
    check("incl_model_res", res_new, 15);
    for (int i = 0; i < 5; i++) begin
      rd_check(i, "incl_arr");
      check("incl_model_arr", model_mem[i], exp_incl[i]);
    end

    // exclusive prefix sum
    for (int i = 0; i < 5; i++) wr_arr(i, i + 1);
    start_scan(0, 5, 10, 1, 0, BIG);
    wait_done();
    check("excl_model_res", res_new, 25);
    for (int i = 0; i < 5; i++) begin
      rd_check(i, "excl_arr");
      check("excl_model_arr", model_mem[i], exp_excl[i]);
    end

    // reduce only
    for (int i = 0; i < 5; i++) wr_arr(i, i + 1);
    start_scan(2, 5, -3, 2, 0, BIG);
    wait_done();
    check("reduce_model_res", res_new, 9);
    for (int i = 0; i < 5; i++) rd_check(i, "reduce_arr");

    // empty range
    start_scan(7, 7, 42, 0, 0, BIG);
    wait_wen("empty_latency", 2);
    wait_done();
    check("empty_model_res", res_new, 42);
    rd_check(7, "empty_arr");

    // end clamp, init beyond depth, mode 3
    wr_arr(10, 7); wr_arr(11, -2);
    start_scan(10, 20, 1, 3, 0, BIG);
    wait_done();
    check("clamp_model_res", res_new, 6);
    rd_check(10, "clamp_arr10"); rd_check(11, "clamp_arr11");
    start_scan(14, 16, -5, 0, 0, BIG);
    wait_done();

    // abort mid-scan: two inclusive writes land, then reduce over the result
    for (int i = 0; i < 5; i++) wr_arr(i, i + 1);
    start_scan(0, 5, 0, 0, 0, 2);
    repeat (4) @(posedge clk);
    #1;
    start_scan(0, 5, 0, 2, 0, BIG);
    wait_done();
    check("abort_model_res", res_new, 16);
    for (int i = 0; i < 5; i++) rd_check(i, "abort_arr");

    // restart in the FIN cycle: w_enable must not rise for the first scan
    start_scan(0, 1, 5, 2, 0, BIG);
    repeat (2) @(posedge clk);
    #1;
    start_scan(1, 3, 0, 2, 0, BIG);
    wait_done();

    // external stall of 5 cycles during an RD cycle
    for (int i = 0; i < 5; i++) wr_arr(i, i + 1);
    start_scan(0, 4, 0, 0, 5, BIG);
    repeat (2) @(posedge clk);
    #1;
    controlArr = 1'b1; controlArrWEnable_a = 1'b0; controlArrAddr_a = AW'(0);
    @(posedge clk); #1;
    check("stall_read_a0", $signed(controlArrRData_a), 1);
    repeat (4) @(posedge clk);
    #1 controlArr = 1'b0;
    wait_wen("stall_latency", 15);
    wait_done();
    check("stall_model_res", res_new, 10);
    for (int i = 0; i < 4; i++) rd_check(i, "stall_arr");

    // async reset mid-scan
    start_scan(0, 5, 0, 2, 0, BIG);
    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wen", w_enable, 0);
    check("rst_mid_result", $signed(result), 0);
    wen_valid = 1'b0; start_cyc = 0; done_cyc = 0; res_old = 0; res_new = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // overflow: wrap or saturate
    wr_arr(0, 100); wr_arr(1, 100);
    start_scan(0, 2, 0, 0, 0, BIG);
    wait_done();
    rd_check(0, "ovf_arr0"); rd_check(1, "ovf_arr1");
`ifdef ACCUM_SAT_EN
    check("sat_model_res", res_new, 127);
    check("sat_model_arr1", model_mem[1], 127);
    check("sat_ovf", ovf, 1);
`else
    check("wrap_model_res", res_new, -56);
    check("wrap_model_arr1", model_mem[1], -56);
`endif
    check("ovf_result", $signed(result), res_new);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
